// File: rtl/bp_pkg.sv
// Branch prediction types shared by fetch, predictor and branch_resolve_unit.
package bp_pkg;

  localparam int unsigned PC_W       = 4;
  localparam int unsigned MISS_CNT_W = 8;

  typedef struct packed {
    logic [PC_W-1:0] pc;
    logic            taken;
    logic [PC_W-1:0] target;
  } pred_entry_t;

  // Fall-through PC of a branch; wraps at the top of the PC space.
  function automatic logic [PC_W-1:0] pc_incr(input logic [PC_W-1:0] pc);
    return pc + PC_W'(1);
  endfunction

endpackage

// File: rtl/branch_resolve_unit_if.sv
// Fetch/execute-facing bundle of branch_resolve_unit: prediction push, resolve, update and flush.
interface branch_resolve_unit_if;
  import bp_pkg::*;

  logic                  pred_valid;
  logic                  pred_ready;
  logic [PC_W-1:0]       pred_pc;
  logic                  pred_taken;
  logic [PC_W-1:0]       pred_target;
  logic                  res_valid;
  logic                  res_taken;
  logic [PC_W-1:0]       res_target;
  logic                  branch_resolved_pc_valid;
  logic [PC_W-1:0]       branch_resolved_pc;
  logic [PC_W-1:0]       branch_resolved_target_pc;
  logic                  branch_resolved_taken;
  logic                  flush;
  logic [PC_W-1:0]       redirect_pc;
  logic [MISS_CNT_W-1:0] mispredict_count;
  logic                  underflow_err;

  modport master (
    output pred_valid, pred_pc, pred_taken, pred_target,
    output res_valid, res_taken, res_target,
    input  pred_ready, branch_resolved_pc_valid, branch_resolved_pc,
    input  branch_resolved_target_pc, branch_resolved_taken,
    input  flush, redirect_pc, mispredict_count, underflow_err
  );

  modport slave (
    input  pred_valid, pred_pc, pred_taken, pred_target,
    input  res_valid, res_taken, res_target,
    output pred_ready, branch_resolved_pc_valid, branch_resolved_pc,
    output branch_resolved_target_pc, branch_resolved_taken,
    output flush, redirect_pc, mispredict_count, underflow_err
  );
endinterface

// File: rtl/bru_pred_fifo.sv
// In-order circular queue of in-flight predictions; clear wins over push/pop.
module bru_pred_fifo
  import bp_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        push,
  input  logic        pop,
  input  logic        clear,
  input  pred_entry_t din,
  output pred_entry_t head,
  output logic        full,
  output logic        empty
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;

  pred_entry_t      mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full && !clear;
  assign do_pop  = pop && !empty && !clear;
  assign head    = mem[rd_ptr];

  // DEPTH is a power of two, so pointers wrap by natural overflow.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/branch_resolve_unit.sv
// Pairs execute-stage resolves with queued predictions, emitting predictor updates and flushes.
// Build option: BRU_UPDATE_ALL_EN strobes the predictor update on every resolve, not just mispredicts.
module branch_resolve_unit
  import bp_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  branch_resolve_unit_if.slave  bus
);

  pred_entry_t           head_c;
  pred_entry_t           push_entry_c;
  logic                  full_c;
  logic                  empty_c;
  logic                  resolve_c;
  logic                  mispredict_c;
  logic                  strobe_c;

  logic                  upd_valid_q;
  logic [PC_W-1:0]       upd_pc_q;
  logic [PC_W-1:0]       upd_target_q;
  logic                  upd_taken_q;
  logic                  flush_q;
  logic [PC_W-1:0]       redirect_q;
  logic [MISS_CNT_W-1:0] miss_cnt_q;
  logic                  underflow_q;

  assign push_entry_c = '{pc: bus.pred_pc, taken: bus.pred_taken, target: bus.pred_target};
  assign resolve_c    = bus.res_valid && !empty_c;
  assign mispredict_c = resolve_c &&
                        ((bus.res_taken != head_c.taken) ||
                         (bus.res_taken && (bus.res_target != head_c.target)));

`ifdef BRU_UPDATE_ALL_EN
  assign strobe_c = resolve_c;
`else
  assign strobe_c = mispredict_c;
`endif

  // A mispredict clears the queue, which also drops any push in the same cycle.
  bru_pred_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (bus.pred_valid),
    .pop   (resolve_c),
    .clear (mispredict_c),
    .din   (push_entry_c),
    .head  (head_c),
    .full  (full_c),
    .empty (empty_c)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      upd_valid_q  <= 1'b0;
      upd_pc_q     <= '0;
      upd_target_q <= '0;
      upd_taken_q  <= 1'b0;
      flush_q      <= 1'b0;
      redirect_q   <= '0;
      miss_cnt_q   <= '0;
      underflow_q  <= 1'b0;
    end else begin
      upd_valid_q <= strobe_c;
      flush_q     <= mispredict_c;
      if (resolve_c) begin
        upd_pc_q     <= head_c.pc;
        upd_target_q <= bus.res_target;
        upd_taken_q  <= bus.res_taken;
      end
      if (mispredict_c) begin
        redirect_q <= bus.res_taken ? bus.res_target : pc_incr(head_c.pc);
        if (miss_cnt_q != {MISS_CNT_W{1'b1}}) miss_cnt_q <= miss_cnt_q + MISS_CNT_W'(1);
      end
      if (bus.res_valid && empty_c) underflow_q <= 1'b1;
    end
  end

  assign bus.pred_ready                = !full_c;
  assign bus.branch_resolved_pc_valid  = upd_valid_q;
  assign bus.branch_resolved_pc        = upd_pc_q;
  assign bus.branch_resolved_target_pc = upd_target_q;
  assign bus.branch_resolved_taken     = upd_taken_q;
  assign bus.flush                     = flush_q;
  assign bus.redirect_pc               = redirect_q;
  assign bus.mispredict_count          = miss_cnt_q;
  assign bus.underflow_err             = underflow_q;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Self-checking bench for branch_resolve_unit: directed table, corner sequences, random vs queue model.
module tb_branch_resolve_unit;
  import bp_pkg::*;

  localparam int unsigned DEPTH = 4;
`ifdef BRU_UPDATE_ALL_EN
  localparam bit UPDATE_ALL = 1'b1;
`else
  localparam bit UPDATE_ALL = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  branch_resolve_unit_if bus ();

  branch_resolve_unit #(.DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_vec = 0;
  int n_bad = 0;

  // Reference model: a plain queue of outstanding predictions plus the expected outputs.
  pred_entry_t mq[$];
  int          m_mcount;
  bit          m_uf, m_flush, m_strobe, m_taken;
  logic [3:0]  m_redir, m_pc, m_tgt;

  typedef struct {
    bit pv; logic [3:0] ppc; bit pt; logic [3:0] ptg;
    bit rv; bit rt; logic [3:0] rtg;
    bit e_flush; logic [3:0] e_redir;
    bit e_str_all; bit e_str_mis;
    logic [3:0] e_pc; logic [3:0] e_tgt; bit e_taken;
    int e_mc;
  } vec_t;

  vec_t tbl[7];

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_mcount = 0; m_uf = 0; m_flush = 0; m_strobe = 0; m_taken = 0;
    m_redir = '0; m_pc = '0; m_tgt = '0;
  endtask

  task automatic compare_all();
    check("pred_ready", int'(bus.pred_ready), int'(mq.size() != DEPTH));
    check("flush", int'(bus.flush), int'(m_flush));
    check("strobe", int'(bus.branch_resolved_pc_valid), int'(m_strobe));
    check("underflow_err", int'(bus.underflow_err), int'(m_uf));
    check("mispredict_count", int'(bus.mispredict_count), m_mcount);
    if (m_flush) check("redirect_pc", int'(bus.redirect_pc), int'(m_redir));
    if (m_strobe) begin
      check("upd_pc", int'(bus.branch_resolved_pc), int'(m_pc));
      check("upd_target", int'(bus.branch_resolved_target_pc), int'(m_tgt));
      check("upd_taken", int'(bus.branch_resolved_taken), int'(m_taken));
    end
  endtask

  // One clock cycle: drive inputs, step the model, then compare after the edge.
  task automatic apply(input bit pv, input logic [3:0] ppc, input bit pt, input logic [3:0] ptg,
                       input bit rv, input bit rt, input logic [3:0] rtg);
    pred_entry_t e, n;
    bit ready, mis;
    bus.pred_valid = pv; bus.pred_pc = ppc; bus.pred_taken = pt; bus.pred_target = ptg;
    bus.res_valid = rv; bus.res_taken = rt; bus.res_target = rtg;
    ready = (mq.size() != DEPTH);
    mis = 0; m_flush = 0; m_strobe = 0;
    if (rv) begin
      if (mq.size() == 0) m_uf = 1;
      else begin
        e = mq.pop_front();
        mis = (rt != e.taken) || (rt && rtg != e.target);
        m_strobe = UPDATE_ALL ? 1'b1 : mis;
        m_flush = mis;
        m_pc = e.pc; m_tgt = rtg; m_taken = rt;
        if (mis) begin
          mq.delete();
          if (m_mcount < 255) m_mcount++;
          m_redir = rt ? rtg : 4'((int'(e.pc) + 1) % 16);
        end
      end
    end
    if (pv && ready && !mis) begin
      n.pc = ppc; n.taken = pt; n.target = ptg;
      mq.push_back(n);
    end
    @(posedge clk); #1;
    compare_all();
    bus.pred_valid = 0; bus.res_valid = 0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ready"}, int'(bus.pred_ready), 1);
    check({tag, "_flush"}, int'(bus.flush), 0);
    check({tag, "_strobe"}, int'(bus.branch_resolved_pc_valid), 0);
    check({tag, "_uf"}, int'(bus.underflow_err), 0);
    check({tag, "_mcount"}, int'(bus.mispredict_count), 0);
    check({tag, "_redirect"}, int'(bus.redirect_pc), 0);
    check({tag, "_upd_pc"}, int'(bus.branch_resolved_pc), 0);
    check({tag, "_upd_tgt"}, int'(bus.branch_resolved_target_pc), 0);
    check({tag, "_upd_taken"}, int'(bus.branch_resolved_taken), 0);
  endtask

  initial begin
    bit exp_str;
    bit rv, rt;
    logic [3:0] rtg;

    tbl[0] = '{1, 3, 1, 9,  0, 0, 0,  0, 0,  0, 0,  0, 0, 0,  0};
    tbl[1] = '{0, 0, 0, 0,  1, 1, 9,  0, 0,  1, 0,  3, 9, 1,  0};
    tbl[2] = '{1, 5, 0, 0,  0, 0, 0,  0, 0,  0, 0,  0, 0, 0,  0};
    tbl[3] = '{0, 0, 0, 0,  1, 1, 2,  1, 2,  1, 1,  5, 2, 1,  1};
    tbl[4] = '{1, 15, 1, 4, 0, 0, 0,  0, 0,  0, 0,  0, 0, 0,  1};
    tbl[5] = '{0, 0, 0, 0,  1, 0, 0,  1, 0,  1, 1,  15, 0, 0, 2};
    tbl[6] = '{0, 0, 0, 0,  0, 0, 0,  0, 0,  0, 0,  0, 0, 0,  2};

    bus.pred_valid = 0; bus.pred_pc = 0; bus.pred_taken = 0; bus.pred_target = 0;
    bus.res_valid = 0; bus.res_taken = 0; bus.res_target = 0;
    model_reset();
    reset = 1;
    #12;
    check_reset_outputs("por");
    @(posedge clk); #1;
    reset = 0;

    // Directed single-branch cases: correct predict, not-taken mispredict, PC wrap.
    for (int i = 0; i < 7; i++) begin
      apply(tbl[i].pv, tbl[i].ppc, tbl[i].pt, tbl[i].ptg, tbl[i].rv, tbl[i].rt, tbl[i].rtg);
      exp_str = UPDATE_ALL ? tbl[i].e_str_all : tbl[i].e_str_mis;
      check($sformatf("tbl%0d_flush", i), int'(bus.flush), int'(tbl[i].e_flush));
      check($sformatf("tbl%0d_strobe", i), int'(bus.branch_resolved_pc_valid), int'(exp_str));
      check($sformatf("tbl%0d_mcount", i), int'(bus.mispredict_count), tbl[i].e_mc);
      if (tbl[i].e_flush)
        check($sformatf("tbl%0d_redirect", i), int'(bus.redirect_pc), int'(tbl[i].e_redir));
      if (exp_str) begin
        check($sformatf("tbl%0d_pc", i), int'(bus.branch_resolved_pc), int'(tbl[i].e_pc));
        check($sformatf("tbl%0d_tgt", i), int'(bus.branch_resolved_target_pc), int'(tbl[i].e_tgt));
        check($sformatf("tbl%0d_taken", i), int'(bus.branch_resolved_taken), int'(tbl[i].e_taken));
      end
    end

    // Fill to full, refused 5th push, resolve while pushing into a full queue, ordered drain.
    for (int i = 1; i <= 4; i++) apply(1, 4'(i), i[0], 4'(i + 8), 0, 0, 0);
    check("full_ready", int'(bus.pred_ready), 0);
    apply(1, 7, 0, 0, 0, 0, 0);
    check("full_refused_ready", int'(bus.pred_ready), 0);
    apply(1, 8, 0, 0, 1, 1, 9);
    check("after_pop_ready", int'(bus.pred_ready), 1);
    apply(0, 0, 0, 0, 1, 0, 3);
    apply(0, 0, 0, 0, 1, 1, 11);
    apply(0, 0, 0, 0, 1, 1, 6);
    check("order_last_pc", int'(bus.branch_resolved_pc), 4);
    check("order_last_redirect", int'(bus.redirect_pc), 6);

    // Mispredict on the oldest of three with a concurrent push: queue emptied, push lost.
    for (int i = 10; i <= 12; i++) apply(1, 4'(i), 0, 0, 0, 0, 0);
    apply(1, 13, 0, 0, 1, 1, 5);
    check("flush_drop_flush", int'(bus.flush), 1);
    check("flush_drop_ready", int'(bus.pred_ready), 1);
    apply(0, 0, 0, 0, 1, 0, 0);
    check("underflow_set", int'(bus.underflow_err), 1);
    check("underflow_no_flush", int'(bus.flush), 0);
    check("underflow_no_strobe", int'(bus.branch_resolved_pc_valid), 0);

    // Saturate the mispredict counter.
    for (int i = 0; i < 260; i++) begin
      apply(1, 4'(i), 0, 0, 0, 0, 0);
      apply(0, 0, 0, 0, 1, 1, 4'(i));
    end
    check("mcount_saturated", int'(bus.mispredict_count), 255);

    // Asynchronous reset with entries in flight.
    apply(1, 2, 1, 3, 0, 0, 0);
    apply(1, 4, 0, 0, 1, 0, 0);
    bus.pred_valid = 1; bus.res_valid = 1;
    #2 reset = 1;
    #1;
    model_reset();
    check_reset_outputs("mid");
    @(posedge clk); #1;
    check_reset_outputs("held");
    bus.pred_valid = 0; bus.res_valid = 0;
    reset = 0;
    apply(0, 0, 0, 0, 1, 1, 1);
    check("post_reset_no_strobe", int'(bus.branch_resolved_pc_valid), 0);

    // Random traffic against the queue model.
    for (int i = 0; i < 3000; i++) begin
      rv = ($urandom_range(0, 2) == 0);
      if (mq.size() > 0 && $urandom_range(0, 2) != 0) begin
        rt = mq[0].taken;
        rtg = rt ? mq[0].target : 4'($urandom_range(0, 15));
      end else begin
        rt = 1'($urandom_range(0, 1));
        rtg = 4'($urandom_range(0, 15));
      end
      apply(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
            4'($urandom_range(0, 15)), rv, rt, rtg);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/branch_resolve_unit.md
BRANCH_RESOLVE_UNIT -- requirements
Module: branch_resolve_unit

Interface
REQ-001 SHALL have parameter DEPTH, default 4, number of in-flight predicted branches tracked (power of two, 2..8).
REQ-002 SHALL have port clk  input  1  clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port pred_valid  input  1  fetch issues a predicted branch this cycle.
REQ-005 SHALL have port pred_ready  output  1  queue can accept a prediction (not full).
REQ-006 SHALL have port pred_pc  input  4  PC of the fetched branch.
REQ-007 SHALL have port pred_taken  input  1  predicted direction.
REQ-008 SHALL have port pred_target  input  4  predicted target PC.
REQ-009 SHALL have port res_valid  input  1  execute resolves the oldest in-flight branch this cycle.
REQ-010 SHALL have port res_taken  input  1  actual direction.
REQ-011 SHALL have port res_target  input  4  actual target PC.
REQ-012 SHALL have port branch_resolved_pc_valid  output  1  one-cycle predictor update strobe.
REQ-013 SHALL have ports branch_resolved_pc / branch_resolved_target_pc  output  4 each  update index and actual target.
REQ-014 SHALL have port branch_resolved_taken  output  1  actual direction for update.
REQ-015 SHALL have ports flush  output  1  and redirect_pc  output  4  mispredict pipeline flush and restart PC.
REQ-016 SHALL have ports mispredict_count  output  8  and underflow_err  output  1.

Function
REQ-017 SHALL hold predictions in an in-order circular queue of DEPTH entries {pc, taken, target}, with wrapping read/write pointers plus an occupancy count of width log2(DEPTH)+1.
REQ-018 SHALL accept a push when pred_valid and pred_ready are both high; pred_ready SHALL equal (count != DEPTH).
REQ-019 SHALL pair res_valid with the oldest queue entry; mispredict = (res_taken != entry.taken) OR (res_taken AND res_target != entry.target).
REQ-020 SHALL register all outputs, giving a latency of one cycle from the accepted res_valid to the update/flush outputs.
REQ-021 On mispredict: flush=1 for exactly one cycle; redirect_pc = res_target if res_taken else entry.pc+1, modulo 16 (15 -> 0).
REQ-022 On mispredict, the queue SHALL be emptied at the same edge (all younger entries discarded), and a push presented in that same cycle SHALL be dropped.
REQ-023 Without mispredict, simultaneous push and resolve SHALL leave count unchanged; a push into a full queue that resolves in the same cycle SHALL be refused, since pred_ready is low.
REQ-024 res_valid while the queue is empty SHALL be ignored (no strobe, no flush) and SHALL set underflow_err sticky until reset.
REQ-025 mispredict_count SHALL increment by 1 per mispredict and saturate at 255.
REQ-026 When no accepted resolve occurred in the prior cycle, branch_resolved_pc_valid and flush SHALL be 0; the data outputs SHALL hold their last values.

Reset
REQ-027 Reset asserted SHALL immediately clear pointers and count (queue empty), flush, branch_resolved_pc_valid, underflow_err and mispredict_count to 0, and redirect_pc and the branch_resolved_* data outputs to 0.
REQ-028 Reset mid-operation SHALL discard in-flight entries without producing an update strobe; pred_ready SHALL be 1 while reset is held and after it is released.

Configuration
REQ-029 With macro BRU_UPDATE_ALL_EN defined, branch_resolved_pc_valid SHALL pulse for every accepted resolve.
REQ-030 Without BRU_UPDATE_ALL_EN, branch_resolved_pc_valid SHALL pulse only on mispredicts; flush behaviour is identical in both builds.

Structure
REQ-031 SHALL import from shared package bp_pkg the constant PC_W=4 and the typedef pred_entry_t {pc, taken, target}, shared with the predictor and the fetch stage.
REQ-032 SHALL implement the queue as sub-module bru_pred_fifo (push, pop, clear, full, empty, head); the comparison and counters stay in the top level.

Verification
REQ-033 Push {pc=3, taken=1, target=9}, resolve taken=1 target=9 -> no flush; strobe only with BRU_UPDATE_ALL_EN, showing pc=3, target=9, taken=1.
REQ-034 Push {pc=5, taken=0}, resolve taken=1 target=2 -> next cycle flush=1, redirect_pc=2, strobe pc=5 target=2 taken=1, count=1.
REQ-035 Push {pc=15, taken=1, target=4}, resolve taken=0 -> flush=1, redirect_pc=0 (wrap).
REQ-036 Push 4 entries -> pred_ready=0 and a 5th push is refused; resolve the oldest entry correctly while pushing -> pred_ready returns to 1, FIFO order preserved.
REQ-037 Three entries queued, oldest mispredicts while a push is presented -> queue empty afterwards, push dropped, next resolve sets underflow_err=1.
REQ-038 Force 256 mispredicts -> mispredict_count holds at 255; assert reset mid-stream -> all outputs 0 and pred_ready=1.
